fft_frame_writer: RTL and testbench
===================================

Name: fft_frame_writer

Overview:
Write-side counterpart of the 128x8 sine/sample table read path used by the FFT datapath. Accepts a valid/ready sample stream and writes exactly one frame of 2**ADDR_WIDTH samples into a single-port RAM write interface. Raises frame_done when the frame is complete and holds it until acknowledged. Sits between the ADC/sample source and the FFT input buffer RAM.

Parameters:
ADDR_WIDTH, 7, RAM address width; frame length FRAME_LEN = 2**ADDR_WIDTH (128).
DATA_WIDTH, 8, sample and RAM data width.
OVF_WIDTH, 8, width of the saturating dropped-sample counter.

Ports:
clk  input  1  clock; all logic on rising edge.
tb_rst  input  1  asynchronous, active-high reset.
start  input  1  single-cycle request to capture one frame; honoured only in IDLE.
abort  input  1  cancel an in-progress capture; honoured only in FILL.
s_valid  input  1  source sample valid.
s_data  input  DATA_WIDTH  source sample.
s_ready  output  1  block accepts a sample this cycle; high exactly when state==FILL.
wr_en  output  1  RAM write strobe, registered.
wr_addr  output  ADDR_WIDTH  RAM write address, registered.
wr_data  output  DATA_WIDTH  RAM write data, registered.
busy  output  1  high in FILL.
frame_done  output  1  high in DONE.
done_ack  input  1  releases DONE back to IDLE.
ovf_cnt  output  OVF_WIDTH  count of s_valid cycles seen while s_ready==0.

Behaviour:
- States: IDLE, FILL, DONE. Register state; s_ready, busy and frame_done are decoded from state.
- Reset (tb_rst=1, asynchronous): state=IDLE; wr_en=0; wr_addr=0; wr_data=0; ovf_cnt=0; internal sample counter cnt=0. Consequently s_ready=0, busy=0, frame_done=0.
- IDLE: start=1 -> FILL on the next edge; cnt cleared to 0; ovf_cnt cleared to 0.
- FILL: a sample is accepted on any edge where s_valid=1.
  - On accept: on the same edge, wr_en<=1, wr_addr<=addr_map(cnt), wr_data<=s_data, and cnt increments.
  - Write appears on the RAM port 1 cycle after the accepting edge.
  - Edges without accept drive wr_en<=0; wr_addr and wr_data hold their values.
- Last sample: accept with cnt==FRAME_LEN-1 -> DONE on the same edge; cnt wraps to 0. The final write (wr_addr=FRAME_LEN-1) is strobed in the first DONE cycle.
- abort in FILL -> IDLE on the next edge; cnt=0; no further writes. A write already registered on that edge still completes. If abort and a last-sample accept coincide, abort wins: go to IDLE, but the final sample's write is still issued.
- DONE: s_ready=0. done_ack=1 -> IDLE on the next edge. start is ignored in DONE and in FILL. done_ack is ignored outside DONE.
- Back-to-back frames: start may be asserted in the same cycle IDLE is entered from DONE; it takes effect on the next edge.
- ovf_cnt: increments on every edge where s_valid=1 and state!=FILL. It saturates at 2**OVF_WIDTH-1 and clears only on reset or an accepted start.
- addr_map(cnt)=cnt (linear) unless the optional feature is enabled.
- Exactly FRAME_LEN writes occur per completed frame. Every address 0..FRAME_LEN-1 is written exactly once; no address is written twice.
- Reset mid-FILL: outputs return immediately to reset values, and the partial frame is abandoned.

Optional Feature:
Macro FFT_FRAME_WRITER_BITREV_EN.
- Defined: addr_map(cnt) is the ADDR_WIDTH-bit bit-reversal of cnt, so the RAM holds the frame in bit-reversed order for a decimation-in-time FFT. Example for ADDR_WIDTH=7: sample 1 -> addr 64, sample 2 -> addr 32, sample 127 -> addr 127.
- Not defined: linear addressing. All other behaviour, including timing, is identical.

Test Plan:
- Reset, then start pulse, then s_valid held high with s_data=k for sample k (k=0..127) -> 128 wr_en pulses, wr_addr=k, wr_data=k, each 1 cycle after accept. frame_done rises on the edge accepting sample 127. busy is high for exactly 128 cycles.
- In FILL, toggle s_valid 1,0,1,0 -> wr_en pulses only after valid cycles. wr_addr stays contiguous 0,1,2,… with no gaps or repeats.
- Assert s_valid for 10 cycles in IDLE and 5 cycles in DONE -> ovf_cnt=15. Drive 300 s_valid cycles in IDLE -> ovf_cnt saturates at 255. Next start -> ovf_cnt=0.
- Assert abort after 40 samples -> exactly 40 writes (addr 0..39), state returns to IDLE, frame_done stays 0. A following start writes addr 0..127 afresh.
- Assert tb_rst mid-frame (after 60 samples) -> wr_en, busy and s_ready go to 0 immediately, without waiting for a clock edge. After release, start plus 128 samples complete normally.
- With FFT_FRAME_WRITER_BITREV_EN defined, samples 0,1,2,3 -> wr_addr 0,64,32,96. Sample 127 -> addr 127. Each address is written once per frame.

Source files
------------

// File: rtl/fft_frame_writer_if.sv
// Sample-stream and RAM-write bundle for fft_frame_writer.
// master = sample source / controller side, slave = the frame writer.
interface fft_frame_writer_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int OVF_WIDTH  = 8
);
    logic                  start;
    logic                  abort;
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  busy;
    logic                  frame_done;
    logic                  done_ack;
    logic [OVF_WIDTH-1:0]  ovf_cnt;

    modport master (
        output start, abort, s_valid, s_data, done_ack,
        input  s_ready, wr_en, wr_addr, wr_data, busy, frame_done, ovf_cnt
    );

    modport slave (
        input  start, abort, s_valid, s_data, done_ack,
        output s_ready, wr_en, wr_addr, wr_data, busy, frame_done, ovf_cnt
    );
endinterface

// File: rtl/fft_frame_writer.sv
// Captures one frame of 2**ADDR_WIDTH samples from a valid/ready stream into a RAM write port.
// Define FFT_FRAME_WRITER_BITREV_EN to store the frame in bit-reversed address order.
module fft_frame_writer #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int OVF_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    tb_rst,
    fft_frame_writer_if.slave       bus
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [OVF_WIDTH-1:0]  ovf_q, ovf_d;

    function automatic logic [ADDR_WIDTH-1:0] addr_map(input logic [ADDR_WIDTH-1:0] c);
        logic [ADDR_WIDTH-1:0] r;
`ifdef FFT_FRAME_WRITER_BITREV_EN
        for (int unsigned i = 0; i < ADDR_WIDTH; i++) begin
            r[i] = c[ADDR_WIDTH-1-i];
        end
`else
        r = c;
`endif
        return r;
    endfunction

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ovf_d     = ovf_q;

        if (bus.s_valid && state_q != FILL && ovf_q != '1) begin
            ovf_d = ovf_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    ovf_d   = '0;
                end
            end
            FILL: begin
                if (bus.s_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_map(cnt_q);
                    wr_data_d = bus.s_data;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = DONE;
                    end
                end
                // Abort overrides the last-sample transition, but the write above still issues.
                if (bus.abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                if (bus.done_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.s_ready    = (state_q == FILL);
    assign bus.busy       = (state_q == FILL);
    assign bus.frame_done = (state_q == DONE);
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.ovf_cnt    = ovf_q;
endmodule

// File: tb/tb_fft_frame_writer.sv
// Directed bench for fft_frame_writer with a frame-level reference model and RAM mirror.
// Honours FFT_FRAME_WRITER_BITREV_EN for the expected address order.
module tb_fft_frame_writer;
    localparam int AW  = 7;
    localparam int DW  = 8;
    localparam int OW  = 8;
    localparam int LEN = 1 << AW;

    logic clk = 1'b0;
    logic tb_rst = 1'b0;
    always #5 clk = ~clk;

    fft_frame_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OVF_WIDTH(OW)) bus ();

    fft_frame_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OVF_WIDTH(OW)) dut (
        .clk    (clk),
        .tb_rst (tb_rst),
        .bus    (bus)
    );

    int checks = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int map_addr(input int c);
        int r;
        int v;
`ifdef FFT_FRAME_WRITER_BITREV_EN
        r = 0;
        v = c;
        for (int i = 0; i < AW; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
`else
        r = c;
        v = 0;
`endif
        return r + v * 0;
    endfunction

    // Reference model: where the capture is, how many samples it has, what the RAM port shows.
    bit capturing, frame_ready;
    int taken, dropped;
    int exp_we, exp_addr, exp_data;

    always @(posedge clk or posedge tb_rst) begin
        bit was_cap, was_rdy;
        if (tb_rst) begin
            capturing = 0; frame_ready = 0; taken = 0; dropped = 0;
            exp_we = 0; exp_addr = 0; exp_data = 0;
        end else begin
            was_cap = capturing;
            was_rdy = frame_ready;
            exp_we  = 0;
            if (bus.s_valid && !was_cap && dropped < (1 << OW) - 1) dropped++;
            if (was_cap && bus.s_valid) begin
                exp_we   = 1;
                exp_addr = map_addr(taken);
                exp_data = int'(bus.s_data);
                taken++;
                if (taken == LEN) begin
                    taken = 0; capturing = 0; frame_ready = 1;
                end
            end
            if (was_cap && bus.abort) begin
                capturing = 0; frame_ready = 0; taken = 0;
            end
            if (!was_cap && !was_rdy && bus.start) begin
                capturing = 1; taken = 0; dropped = 0;
            end
            if (was_rdy && bus.done_ack) frame_ready = 0;
        end
    end

    // RAM mirror plus per-frame bookkeeping, and the per-cycle compare against the model.
    logic [DW-1:0] ram [LEN];
    bit written [LEN];
    int wr_count, busy_cycles;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_en",      32'(bus.wr_en),      32'(exp_we));
            chk("wr_addr",    32'(bus.wr_addr),    32'(exp_addr));
            chk("wr_data",    32'(bus.wr_data),    32'(exp_data));
            chk("s_ready",    32'(bus.s_ready),    32'(capturing));
            chk("busy",       32'(bus.busy),       32'(capturing));
            chk("frame_done", 32'(bus.frame_done), 32'(frame_ready));
            chk("ovf_cnt",    32'(bus.ovf_cnt),    32'(dropped));
            if (bus.busy) busy_cycles++;
            if (bus.wr_en) begin
                chk("wr_once", 32'(written[bus.wr_addr]), 32'd0);
                written[bus.wr_addr] = 1'b1;
                ram[bus.wr_addr] = bus.wr_data;
                wr_count++;
            end
        end
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic start_frame();
        for (int i = 0; i < LEN; i++) written[i] = 1'b0;
        wr_count = 0;
        busy_cycles = 0;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic send(input int n, input bit gaps, input logic [DW-1:0] xr);
        for (int k = 0; k < n; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = DW'(k) ^ xr;
            cyc();
            if (gaps) begin
                bus.s_valid = 1'b0;
                cyc();
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic valid_idle(input int n);
        bus.s_valid = 1'b1;
        cyc(n);
        bus.s_valid = 1'b0;
    endtask

    initial begin
        bus.start = 0; bus.abort = 0; bus.s_valid = 0; bus.s_data = '0; bus.done_ack = 0;
        #1 tb_rst = 1'b1;
        #1 chk_en = 1'b1;
        cyc(3);
        tb_rst = 1'b0;
        cyc();
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ovf", 32'(bus.ovf_cnt), 0);

        // Full linear-stimulus frame.
        start_frame();
        send(LEN, 1'b0, '0);
        cyc(3);
        chk("f1_done", 32'(bus.frame_done), 1);
        chk("f1_writes", 32'(wr_count), 128);
        chk("f1_busy_cycles", 32'(busy_cycles), 128);
`ifdef FFT_FRAME_WRITER_BITREV_EN
        chk("ram_64", 32'(ram[64]), 1);
        chk("ram_32", 32'(ram[32]), 2);
        chk("ram_96", 32'(ram[96]), 3);
`else
        chk("ram_1", 32'(ram[1]), 1);
        chk("ram_2", 32'(ram[2]), 2);
        chk("ram_3", 32'(ram[3]), 3);
`endif
        chk("ram_127", 32'(ram[127]), 127);

        // Dropped samples: 5 in DONE, 10 in IDLE.
        valid_idle(5);
        bus.done_ack = 1'b1;
        cyc();
        bus.done_ack = 1'b0;
        valid_idle(10);
        chk("ovf_15", 32'(bus.ovf_cnt), 15);

        // Gapped stream, then back-to-back start in the cycle IDLE is re-entered.
        start_frame();
        chk("ovf_clr1", 32'(bus.ovf_cnt), 0);
        send(LEN, 1'b1, 8'h5A);
        cyc(2);
        chk("f2_writes", 32'(wr_count), 128);
        chk("ram_5_xor", 32'(ram[map_addr(5)]), 32'(8'h5A ^ 8'd5));
        bus.done_ack = 1'b1;
        cyc();
        bus.done_ack = 1'b0;
        start_frame();
        chk("b2b_busy", 32'(bus.busy), 1);
        send(LEN, 1'b0, 8'hC3);
        cyc(2);
        chk("f3_writes", 32'(wr_count), 128);
        bus.done_ack = 1'b1;
        cyc();
        bus.done_ack = 1'b0;

        // Saturation of the dropped-sample counter.
        valid_idle(300);
        chk("ovf_sat", 32'(bus.ovf_cnt), 255);

        // Abort after 40 samples, then a fresh full frame.
        start_frame();
        chk("ovf_clr2", 32'(bus.ovf_cnt), 0);
        send(40, 1'b0, '0);
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        cyc(3);
        chk("abort_writes", 32'(wr_count), 40);
        chk("abort_done", 32'(bus.frame_done), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        start_frame();
        send(LEN, 1'b0, '0);
        cyc(2);
        chk("post_abort_writes", 32'(wr_count), 128);
        bus.done_ack = 1'b1;
        cyc();
        bus.done_ack = 1'b0;

        // Abort coinciding with the last sample: final write issued, no DONE.
        start_frame();
        send(LEN - 1, 1'b0, '0);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'd127;
        bus.abort   = 1'b1;
        cyc();
        bus.s_valid = 1'b0;
        bus.abort   = 1'b0;
        cyc(2);
        chk("abort_last_writes", 32'(wr_count), 128);
        chk("abort_last_done", 32'(bus.frame_done), 0);

        // Asynchronous reset in the middle of a frame.
        start_frame();
        bus.s_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            bus.s_data = DW'(k);
            cyc();
        end
        tb_rst = 1'b1;
        #1;
        chk("arst_wr_en", 32'(bus.wr_en), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_s_ready", 32'(bus.s_ready), 0);
        bus.s_valid = 1'b0;
        cyc(2);
        tb_rst = 1'b0;
        cyc();
        start_frame();
        send(LEN, 1'b0, '0);
        cyc(2);
        chk("post_rst_writes", 32'(wr_count), 128);
        chk("post_rst_done", 32'(bus.frame_done), 1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
